// File: rtl/sumnb_acc.sv
// rtl/sumnb_acc.sv - registered add/subtract/accumulate unit with optional saturation
//
// Purpose:
//   Single-cycle-latency arithmetic unit. Each request accepted on a rising
//   clock edge produces a registered result one edge later. The unit supports
//   add-with-carry, subtract, accumulate and accumulator clear. It can either
//   wrap or saturate on signed overflow.
//
// Parameters:
//   WIDTH      operand/result/accumulator width (2..32)
//   SAT        0 = wrap-around results, 1 = saturate on signed overflow
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   In_valid   request strobe, one operation per cycle, never backpressured
//   Mode       00 A+B+Cin | 01 A-B | 10 Acc+A+Cin | 11 clear accumulator
//   A, B, Cin  operands (B ignored in modes 10/11, Cin ignored in 01/11)
//   Sum        registered result
//   Cout       registered carry out of bit WIDTH-1 (01: 1 = no borrow)
//   Ovf        registered signed overflow of the raw add
//   Ovf_sticky OR of Ovf since reset or last clear
//   Out_valid  one-cycle pulse per accepted request
//   Op_count   accepted request count, wraps 255 -> 0
module sumnb_acc #(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Ovf_sticky,
  output logic             Out_valid,
  output logic [7:0]       Op_count
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Architectural state
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             valid_q, valid_d;
  logic [7:0]       cnt_q, cnt_d;

  // Datapath intermediates
  mode_e            mode_w;
  logic [WIDTH-1:0] opa_w;
  logic [WIDTH-1:0] opb_w;
  logic             cin_w;
  logic [WIDTH:0]   raw_w;
  logic             ovf_w;
  logic [WIDTH-1:0] res_w;

  assign mode_w = mode_e'(Mode);

  // Operand selection. Subtraction reuses the adder as A + ~B + 1, so the
  // overflow test below naturally compares A against the inverted B.
  always_comb begin
    opa_w = A;
    opb_w = B;
    cin_w = Cin;
    case (mode_w)
      MODE_ADD: begin
        opa_w = A;
        opb_w = B;
        cin_w = Cin;
      end
      MODE_SUB: begin
        opa_w = A;
        opb_w = ~B;
        cin_w = 1'b1;
      end
      MODE_ACC: begin
        opa_w = acc_q;
        opb_w = A;
        cin_w = Cin;
      end
      MODE_CLR: begin
        opa_w = '0;
        opb_w = '0;
        cin_w = 1'b0;
      end
      default: begin
        opa_w = A;
        opb_w = B;
        cin_w = Cin;
      end
    endcase
  end

  // One extra bit of adder width captures the unsigned carry out.
  always_comb begin
    raw_w = {1'b0, opa_w} + {1'b0, opb_w} + {{WIDTH{1'b0}}, cin_w};
  end

  // Signed overflow: both operands share a sign, result sign differs.
  // The carry-in cannot change this rule because a carry can only push the
  // sign bit when the operand signs already agree.
  always_comb begin
    ovf_w = (opa_w[WIDTH-1] == opb_w[WIDTH-1]) &&
            (raw_w[WIDTH-1] != opa_w[WIDTH-1]);
  end

  // Saturation direction follows the operand sign: two positives overflowing
  // clamp high, two negatives clamp low. Cout/Ovf still describe the raw add.
  always_comb begin
    res_w = raw_w[WIDTH-1:0];
    if (SAT && ovf_w) begin
      res_w = opa_w[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Next-state logic. Idle cycles hold results and drop Out_valid.
  always_comb begin
    sum_d    = sum_q;
    acc_d    = acc_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    if (In_valid) begin
      valid_d = 1'b1;
      cnt_d   = cnt_q + 8'd1;
      if (mode_w == MODE_CLR) begin
        sum_d    = '0;
        acc_d    = '0;
        cout_d   = 1'b0;
        ovf_d    = 1'b0;
        sticky_d = 1'b0;
      end else begin
        sum_d    = res_w;
        cout_d   = raw_w[WIDTH];
        ovf_d    = ovf_w;
        sticky_d = sticky_q | ovf_w;
        if (mode_w == MODE_ACC) begin
          acc_d = res_w;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q    <= '0;
      acc_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      sum_q    <= sum_d;
      acc_q    <= acc_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Sum        = sum_q;
  assign Cout       = cout_q;
  assign Ovf        = ovf_q;
  assign Ovf_sticky = sticky_q;
  assign Out_valid  = valid_q;
  assign Op_count   = cnt_q;

endmodule
